phy_mdio_ctrl: RTL and testbench

PHY_MDIO_CTRL -- requirements
Module: phy_mdio_ctrl

---
 rtl/phy_mdio_ctrl.sv | 156 +++++++++++++++
 tb/tb_phy_mdio_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/phy_mdio_ctrl.sv
// Clause-22 MDIO master: host read/write frames plus periodic BMSR polling for link status.
// One 64-bit frame in flight at a time; cmd_ready is high only in IDLE. rsp_valid comes 1+128*MDC_DIV cycles after accept.
module phy_mdio_ctrl #(
  parameter int unsigned MDC_DIV     = 25,
  parameter logic [4:0]  PHY_ADDR    = 5'd0,
  parameter int unsigned POLL_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        link_up,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRAME = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam int unsigned PCW = $clog2(POLL_CYCLES);

  logic [1:0]     state_q, state_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic           poll_pend_q, poll_pend_d;
  logic           is_poll_q, is_poll_d;
  logic           is_wr_q, is_wr_d;
  logic [4:0]     reg_q, reg_d;
  logic [63:0]    frame_q, frame_d;
  logic [5:0]     bit_q, bit_d;
  logic           phase_q, phase_d;
  logic [7:0]     div_q, div_d;
  logic [15:0]    rdata_q, rdata_d;
  logic [15:0]    rsp_rdata_q, rsp_rdata_d;
  logic           link_q, link_d;
  logic           mdc_q, mdc_d;
  logic           mdo_q, mdo_d;
  logic           moe_q, moe_d;
  logic           poll_wrap;
  logic           div_end;

  always_comb begin
    state_d     = state_q;
    poll_pend_d = poll_pend_q;
    is_poll_d   = is_poll_q;
    is_wr_d     = is_wr_q;
    reg_d       = reg_q;
    frame_d     = frame_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    div_d       = div_q;
    rdata_d     = rdata_q;
    rsp_rdata_d = rsp_rdata_q;
    link_d      = link_q;

    // Free-running poll timer; a wrap while a poll is still pending is simply absorbed.
    poll_wrap   = (poll_cnt_q == PCW'(POLL_CYCLES - 1));
    poll_cnt_d  = poll_wrap ? '0 : poll_cnt_q + PCW'(1);
    poll_pend_d = poll_pend_q | poll_wrap;
    div_end     = (div_q == 8'(MDC_DIV - 1));

    case (state_q)
      IDLE: begin
        if (cmd_valid || poll_pend_q) begin
          state_d   = FRAME;
          is_poll_d = ~cmd_valid;
          is_wr_d   = cmd_valid & cmd_write;
          reg_d     = cmd_valid ? cmd_reg : 5'd1;
          frame_d   = {32'hFFFF_FFFF, 2'b01, (is_wr_d ? 2'b01 : 2'b10), PHY_ADDR, reg_d,
                       (is_wr_d ? {2'b10, cmd_wdata} : 18'h3FFFF)};
          bit_d     = '0;
          phase_d   = 1'b0;
          div_d     = '0;
          if (!cmd_valid) poll_pend_d = 1'b0;
        end
      end
      FRAME: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (phase_q && (div_q == 8'd0) && (bit_q >= 6'd48)) rdata_d = {rdata_q[14:0], mdio_i};
        if (div_end) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            bit_d = bit_q + 6'd1;
            if (bit_q == 6'd63) begin
              state_d = DONE;
              if (!is_poll_q) rsp_rdata_d = is_wr_q ? 16'h0000 : rdata_d;
              if (!is_wr_q && (reg_q == 5'd1)) link_d = rdata_d[2];
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pad outputs are registered from next-state so mdio_o changes on the first low cycle of each bit.
    mdc_d = (state_d == FRAME) && phase_d;
    mdo_d = (state_d == FRAME) ? frame_d[6'd63 - bit_d] : 1'b1;
    moe_d = (state_d == FRAME) && (is_wr_d || (bit_d < 6'd46));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      poll_cnt_q  <= '0;
      poll_pend_q <= 1'b0;
      is_poll_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      reg_q       <= '0;
      frame_q     <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      div_q       <= '0;
      rdata_q     <= '0;
      rsp_rdata_q <= '0;
      link_q      <= 1'b0;
      mdc_q       <= 1'b0;
      mdo_q       <= 1'b1;
      moe_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      poll_pend_q <= poll_pend_d;
      is_poll_q   <= is_poll_d;
      is_wr_q     <= is_wr_d;
      reg_q       <= reg_d;
      frame_q     <= frame_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      div_q       <= div_d;
      rdata_q     <= rdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      link_q      <= link_d;
      mdc_q       <= mdc_d;
      mdo_q       <= mdo_d;
      moe_q       <= moe_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == DONE) && !is_poll_q;
  assign rsp_rdata = rsp_rdata_q;
  assign link_up   = link_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdo_q;
  assign mdio_oe   = moe_q;

endmodule

// File: tb/tb_phy_mdio_ctrl.sv
// Directed bench for phy_mdio_ctrl: a PHY model answers reads from a register array and records
// the serial frame; host responses are scored against a queue of expectations pushed at accept.
module tb_phy_mdio_ctrl;
  localparam int          MDC_DIV     = 2;
  localparam int          POLL_CYCLES = 2000;
  localparam logic [4:0]  PHY_ADDR    = 5'd1;
  localparam int          FRAME_CYC   = 128 * MDC_DIV;
  localparam logic [63:0] RD_MASK     = 64'hFFFF_FFFF_FFFC_0000;
  localparam logic [63:0] ALL1        = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata, rsp_rdata;
  logic        rsp_valid, link_up, busy, mdc, mdio_o, mdio_oe;
  logic        mdio_i = 1'b1;

  phy_mdio_ctrl #(.MDC_DIV(MDC_DIV), .PHY_ADDR(PHY_ADDR), .POLL_CYCLES(POLL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .link_up(link_up), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame(input logic wr, input logic [4:0] r, input logic [15:0] d);
    return {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), PHY_ADDR, r, (wr ? 2'b10 : 2'b00), (wr ? d : 16'h0)};
  endfunction

  // PHY model: counts MDC falling edges as the bit index, records mdio_o/oe at each rising edge,
  // and drives read data for the register address it decoded from the frame.
  logic [15:0] phy_regs [32];
  int          falls = 0;
  int          fstart = 0;
  logic        mdc_prev = 1'b0, busy_prev = 1'b0;
  logic [63:0] cap_o = '0, cap_oe = '0;

  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      falls = 0; cap_o = '0; cap_oe = '0; fstart = cyc;
    end else if (mdc_prev && !mdc) begin
      falls = falls + 1;
    end
    if (mdc && !mdc_prev && falls < 64) begin
      cap_o[63-falls]  = mdio_o;
      cap_oe[63-falls] = mdio_oe;
    end
    mdc_prev  = mdc;
    busy_prev = busy;
    mdio_i    = (falls >= 48 && falls <= 63) ? phy_regs[cap_o[22:18]][63-falls] : 1'b1;
  end

  typedef struct {
    logic [15:0] rdata;
    logic        link;
    int          t_acc;
    logic [63:0] pat;
    logic [63:0] pmask;
    logic [63:0] oe;
  } exp_t;
  exp_t sb[$];
  int   n_rsp = 0;
  int   last_rsp = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      n_rsp++;
      last_rsp = cyc;
      if (sb.size() == 0) begin
        check("unexpected_rsp", rsp_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("rsp_latency", cyc - e.t_acc, FRAME_CYC + 1);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_link_up", link_up, e.link);
        check("ready_in_done", cmd_ready, 1'b0);
        check("frame_mdio_o", cap_o & e.pmask, e.pat & e.pmask);
        check("frame_mdio_oe", cap_oe, e.oe);
      end
    end
  end

  task automatic host_cmd(input logic wr, input logic [4:0] r, input logic [15:0] d,
                          input logic [15:0] exp_rd, input logic exp_link);
    exp_t e;
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_reg = r; cmd_wdata = d;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    check("accept_wait", cmd_ready, 1'b1);
    e.rdata = exp_rd; e.link = exp_link; e.t_acc = cyc;
    e.pat   = frame(wr, r, d);
    e.pmask = wr ? ALL1 : RD_MASK;
    e.oe    = wr ? ALL1 : RD_MASK;
    sb.push_back(e);
    @(negedge clk);
    // Scramble inputs after accept: the frame must use the captured values.
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_reg = ~r; cmd_wdata = ~d;
  endtask

  task automatic wait_sb(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check(tag, sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int c0, n, nr;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_reg = '0; cmd_wdata = '0;
    foreach (phy_regs[i]) phy_regs[i] = 16'h0000;
    phy_regs[1] = 16'h786D;
    phy_regs[2] = 16'h001C;
    phy_regs[3] = 16'hA5C3;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0);
    check("rst_link_up", link_up, 1'b0);
    check("rst_mdc", mdc, 1'b0);
    check("rst_mdio_oe", mdio_oe, 1'b0);
    check("rst_mdio_o", mdio_o, 1'b1);

    // First poll after reset: BMSR link bit set, no host response.
    rst_n = 1'b1; c0 = cyc; nr = n_rsp;
    n = 0;
    while (!busy && n < POLL_CYCLES + 100) begin @(negedge clk); n++; end
    check("poll_start_cycle", cyc - c0, POLL_CYCLES + 1);
    check("poll_link_before", link_up, 1'b0);
    n = 0;
    while (!link_up && n < 400) begin @(negedge clk); n++; end
    check("poll_link_rise_cycle", cyc - fstart, FRAME_CYC);
    check("poll_busy_in_done", busy, 1'b1);
    check("poll_mdio_o", cap_o & RD_MASK, frame(1'b0, 5'd1, 16'h0) & RD_MASK);
    check("poll_mdio_oe", cap_oe, RD_MASK);
    @(negedge clk);
    check("poll_back_idle", busy, 1'b0);
    check("poll_no_rsp", n_rsp, nr);

    // Host write, then back-to-back reads with cmd_valid held through the previous DONE.
    host_cmd(1'b1, 5'd0, 16'h1140, 16'h0000, 1'b1);
    wait_sb("write_done");
    phy_regs[1] = 16'h7869;
    host_cmd(1'b0, 5'd2, 16'h5555, 16'h001C, 1'b1);
    host_cmd(1'b0, 5'd1, 16'h0000, 16'h7869, 1'b0);
    wait_sb("reads_done");

    // Host request lands in the same cycle the second poll becomes pending.
    phy_regs[1] = 16'h786D;
    n = 0;
    while (cyc < c0 + 2 * POLL_CYCLES && n < 5000) begin @(negedge clk); n++; end
    host_cmd(1'b0, 5'd3, 16'h0000, 16'hA5C3, 1'b0);
    wait_sb("arb_host_done");
    nr = n_rsp;
    n = 0;
    while (fstart <= last_rsp && n < 20) begin @(negedge clk); n++; end
    check("arb_poll_gap", fstart - last_rsp, 2);
    n = 0;
    while (!link_up && n < 400) begin @(negedge clk); n++; end
    check("arb_poll_link_cycle", cyc - fstart, FRAME_CYC);
    check("arb_poll_no_rsp", n_rsp, nr);

    // Reset in the middle of a write frame.
    host_cmd(1'b1, 5'd9, 16'h0F0F, 16'h0000, 1'b1);
    n = 0;
    while (falls != 20 && n < 500) begin @(negedge clk); n++; end
    check("abort_bit_reached", falls, 20);
    rst_n = 1'b0; sb.delete(); nr = n_rsp;
    @(negedge clk);
    check("abort_mdio_oe", mdio_oe, 1'b0);
    check("abort_mdc", mdc, 1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_link_up", link_up, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("abort_no_rsp", n_rsp, nr);
    host_cmd(1'b1, 5'd4, 16'hBEEF, 16'h0000, 1'b0);
    wait_sb("fresh_write_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
